// File: rtl/llc_ev_trace_source.sv
// Per-set LLC eviction counter with an epoch-triggered sweep that streams one trace record per set.
// Optional macro LLC_EV_TRACE_DELTA_EN adds the prev[] array and the delta/deltaNeg fields.
module llc_ev_trace_source #(
  parameter int SETS    = 1024,
  parameter int SET_W   = 10,
  parameter int EV_W    = 15,
  parameter int SQ_W    = 40,
  parameter int DELTA_W = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_evict_valid,
  input  logic [SET_W-1:0]   io_evict_set,
  input  logic               io_epoch,
  output logic               io_busy,
  output logic               io_overrun,
  output logic               io_traceout_valid,
  input  logic               io_traceout_ready,
  output logic [SET_W-1:0]   io_traceout_bits_set,
  output logic [EV_W-1:0]    io_traceout_bits_ev,
  output logic [DELTA_W-1:0] io_traceout_bits_delta,
  output logic               io_traceout_bits_deltaNeg,
  output logic [EV_W-1:0]    io_traceout_bits_evSum,
  output logic [SQ_W-1:0]    io_traceout_bits_evSqSum,
  output logic               io_traceout_bits_last
);
  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t             r_state, w_state_nxt;
  logic [EV_W-1:0]    r_cnt [SETS];
  logic [SET_W-1:0]   r_ptr;
  logic               r_cap_done;
  logic               r_vld, r_neg, r_last, r_overrun;
  logic [SET_W-1:0]   r_set;
  logic [EV_W-1:0]    r_ev, r_sum;
  logic [DELTA_W-1:0] r_delta;
  logic [SQ_W-1:0]    r_sq;

  logic               w_fire, w_load, w_start, w_busy, w_ptr_last;
  logic [EV_W-1:0]    w_ev, w_sum_nxt;
  logic [EV_W:0]      w_sum_ext;
  logic [2*EV_W-1:0]  w_sq;
  logic [SQ_W:0]      w_sq_ext;
  logic [SQ_W-1:0]    w_sq_nxt;
  logic [DELTA_W-1:0] w_delta;
  logic               w_neg;

  assign w_fire     = r_vld & io_traceout_ready;
  assign w_load     = (r_state == S_SWEEP) & ~r_cap_done & (~r_vld | w_fire);
  assign w_start    = (r_state == S_IDLE) & io_epoch;
  assign w_ptr_last = (r_ptr == SET_W'(SETS - 1));
  assign w_ev       = r_cnt[r_ptr];

  // Accumulators only grow within a sweep, so a saturating add stays pinned once it hits all-ones.
  assign w_sum_ext = {1'b0, r_sum} + {1'b0, w_ev};
  assign w_sum_nxt = w_sum_ext[EV_W] ? '1 : w_sum_ext[EV_W-1:0];
  assign w_sq      = {{EV_W{1'b0}}, w_ev} * {{EV_W{1'b0}}, w_ev};
  assign w_sq_ext  = {1'b0, r_sq} + (SQ_W+1)'(w_sq);
  assign w_sq_nxt  = w_sq_ext[SQ_W] ? '1 : w_sq_ext[SQ_W-1:0];

`ifdef LLC_EV_TRACE_DELTA_EN
  logic [EV_W-1:0] r_prev [SETS];
  logic [EV_W-1:0] w_pv, w_diff;

  assign w_pv    = r_prev[r_ptr];
  assign w_neg   = (w_ev < w_pv);
  assign w_diff  = w_neg ? (w_pv - w_ev) : (w_ev - w_pv);
  assign w_delta = (|w_diff[EV_W-1:DELTA_W]) ? '1 : w_diff[DELTA_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SETS; i++) r_prev[i] <= '0;
    end else if (w_load) begin
      r_prev[r_ptr] <= w_ev;
    end
  end
`else
  assign w_delta = '0;
  assign w_neg   = 1'b0;
`endif

  // A same-cycle eviction to the set being captured belongs to the next epoch.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SETS; i++) r_cnt[i] <= '0;
    end else begin
      if (w_load) r_cnt[r_ptr] <= '0;
      if (io_evict_valid) begin
        if (w_load && (io_evict_set == r_ptr))
          r_cnt[io_evict_set] <= EV_W'(1);
        else if (~&r_cnt[io_evict_set])
          r_cnt[io_evict_set] <= r_cnt[io_evict_set] + EV_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (io_epoch)              w_state_nxt = S_SWEEP;
      S_SWEEP: if (w_fire && r_last)      w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_SWEEP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr      <= '0;
      r_cap_done <= 1'b0;
      r_vld      <= 1'b0;
      r_set      <= '0;
      r_ev       <= '0;
      r_delta    <= '0;
      r_neg      <= 1'b0;
      r_sum      <= '0;
      r_sq       <= '0;
      r_last     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (io_epoch && (r_state == S_SWEEP)) r_overrun <= 1'b1;
      if (w_start) begin
        r_ptr      <= '0;
        r_cap_done <= 1'b0;
        r_sum      <= '0;
        r_sq       <= '0;
      end
      if (w_load) begin
        r_vld   <= 1'b1;
        r_set   <= r_ptr;
        r_ev    <= w_ev;
        r_delta <= w_delta;
        r_neg   <= w_neg;
        r_sum   <= w_sum_nxt;
        r_sq    <= w_sq_nxt;
        r_last  <= w_ptr_last;
        r_ptr   <= r_ptr + SET_W'(1);
        if (w_ptr_last) r_cap_done <= 1'b1;
      end else if (w_fire) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign io_busy                   = w_busy;
  assign io_overrun                = r_overrun;
  assign io_traceout_valid         = r_vld;
  assign io_traceout_bits_set      = r_set;
  assign io_traceout_bits_ev       = r_ev;
  assign io_traceout_bits_delta    = r_delta;
  assign io_traceout_bits_deltaNeg = r_neg;
  assign io_traceout_bits_evSum    = r_sum;
  assign io_traceout_bits_evSqSum  = r_sq;
  assign io_traceout_bits_last     = r_last;
endmodule
